mem_arbiter: RTL

Two-port arbiter that shares the single unified instruction/data memory between the core's memory interface (port 0) and an external requester such as a program loader or debug/DMA agent (port 1). Each port uses a valid/ready request handshake and receives a one-cycle response pulse. The arbiter registers the winning request, drives the memory for exactly one cycle and returns the read word. It sits between the requesters and the memory's A/WD/WE/RD pins.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of the unified instruction/data memory.
// Port 0 is the core's memory interface and port 1 is an external requester
// (loader, debug or DMA agent). One request is accepted at a time. It is
// registered, presented to the memory for exactly one cycle, and answered with a
// one-cycle response pulse that carries the word read before any write.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   pN_req_valid/ready  request handshake; accepted when valid & ready
//   pN_req_addr/wdata   byte address and write data
//   pN_req_we           byte write enables (0 = read)
//   pN_resp_valid       one-cycle response pulse
//   pN_resp_rdata/err   read word and out-of-range flag, held until the next response
//   mem_a/wd/we/rd      memory pins (mem_rd is combinational read data)
//   busy                high while the memory access is in progress
//   grant_owner         port that owns the current or most recent transaction
module mem_arbiter #(
  parameter int unsigned MEM_SIZE    = 1024,
  parameter bit          P0_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [3:0]  p0_req_we,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [3:0]  p1_req_we,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        grant_owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic [29:0] addr_q;       // word address; the byte offset is never used
  logic [31:0] wdata_q;
  logic [3:0]  we_q;
  logic        owner_q;
  logic        last_grant_q;
  logic        p0_resp_valid_q, p1_resp_valid_q;
  logic [31:0] p0_resp_rdata_q, p1_resp_rdata_q;
  logic        p0_resp_err_q, p1_resp_err_q;

  logic can_accept, pick, acc0, acc1, in_range;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{p0_req_addr[1:0], p1_req_addr[1:0]};

  always_comb begin
    can_accept = (state_q != ACCESS);
    // pick = 1 selects port 1; on a tie round-robin favours the port not granted last
    if (p0_req_valid && p1_req_valid) begin
      pick = P0_PRIORITY ? 1'b0 : ~last_grant_q;
    end else begin
      pick = p1_req_valid;
    end
    acc0 = can_accept & p0_req_valid & ~pick;
    acc1 = can_accept & p1_req_valid & pick;
  end

  assign in_range = ({2'b00, addr_q} < MEM_SIZE);

  assign p0_req_ready  = acc0;
  assign p1_req_ready  = acc1;
  assign mem_a         = {addr_q, 2'b00};
  assign mem_wd        = wdata_q;
  // Decoded from state so that an asynchronous reset removes the strobe at once.
  assign mem_we        = (state_q == ACCESS && in_range) ? we_q : '0;
  assign busy          = (state_q == ACCESS);
  assign grant_owner   = owner_q;
  assign p0_resp_valid = p0_resp_valid_q;
  assign p0_resp_rdata = p0_resp_rdata_q;
  assign p0_resp_err   = p0_resp_err_q;
  assign p1_resp_valid = p1_resp_valid_q;
  assign p1_resp_rdata = p1_resp_rdata_q;
  assign p1_resp_err   = p1_resp_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      we_q            <= '0;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      p0_resp_valid_q <= 1'b0;
      p1_resp_valid_q <= 1'b0;
      p0_resp_rdata_q <= '0;
      p1_resp_rdata_q <= '0;
      p0_resp_err_q   <= 1'b0;
      p1_resp_err_q   <= 1'b0;
    end else begin
      p0_resp_valid_q <= 1'b0;
      p1_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (acc0 || acc1) begin
            addr_q       <= acc1 ? p1_req_addr[31:2] : p0_req_addr[31:2];
            wdata_q      <= acc1 ? p1_req_wdata : p0_req_wdata;
            we_q         <= acc1 ? p1_req_we : p0_req_we;
            owner_q      <= acc1;
            last_grant_q <= acc1;
            state_q      <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          if (owner_q) begin
            p1_resp_valid_q <= 1'b1;
            p1_resp_rdata_q <= in_range ? mem_rd : '0;
            p1_resp_err_q   <= ~in_range;
          end else begin
            p0_resp_valid_q <= 1'b1;
            p0_resp_rdata_q <= in_range ? mem_rd : '0;
            p0_resp_err_q   <= ~in_range;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
